// File: rtl/image_window_ctrl.sv
// 3x3 window producer: buffers a raster pixel stream in four line buffers and
// emits registered 3x3 neighbourhoods, pulsing o_intr each time a line is consumed.
module image_window_ctrl #(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [PIX_W-1:0]   i_pixel_data,
    input  logic               i_pixel_data_valid,
    output logic [9*PIX_W-1:0] o_pixel_data,
    output logic               o_pixel_data_valid,
    output logic               o_intr
);

    localparam int AW = $clog2(IMG_WIDTH);
    localparam int TW = $clog2(4 * IMG_WIDTH + 1);

    localparam logic [AW-1:0] LAST_WR  = AW'(IMG_WIDTH - 1);
    localparam logic [AW-1:0] LAST_RD  = AW'(IMG_WIDTH - 3);
    localparam logic [TW-1:0] LINE_PIX = TW'(IMG_WIDTH);
    localparam logic [TW-1:0] FILL_THR = TW'(3 * IMG_WIDTH);

    localparam logic IDLE = 1'b0;
    localparam logic READ = 1'b1;

    logic [PIX_W-1:0]   lb [4][IMG_WIDTH];
    logic [AW-1:0]      wr_cnt;
    logic [1:0]         wr_sel;
    logic [AW-1:0]      rd_cnt;
    logic [1:0]         rd_sel;
    logic [TW-1:0]      total_pix;
    logic               state;
    logic               line_done;
    logic [9*PIX_W-1:0] window;

    // NOTE: storage has no reset; stale contents are never read because
    // total_pix restarts at zero and must refill three full lines first.
    always_ff @(posedge i_clk) begin
        if (i_pixel_data_valid) begin
            lb[wr_sel][wr_cnt] <= i_pixel_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_cnt <= '0;
            wr_sel <= '0;
        end else if (i_pixel_data_valid) begin
            if (wr_cnt == LAST_WR) begin
                wr_cnt <= '0;
                wr_sel <= wr_sel + 2'd1;
            end else begin
                wr_cnt <= wr_cnt + AW'(1);
            end
        end
    end

    assign line_done = (state == READ) && (rd_cnt == LAST_RD);

    // A write and a line release in the same cycle must both land.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            total_pix <= '0;
        end else begin
            case ({i_pixel_data_valid, line_done})
                2'b10:   total_pix <= total_pix + TW'(1);
                2'b01:   total_pix <= total_pix - LINE_PIX;
                2'b11:   total_pix <= total_pix + TW'(1) - LINE_PIX;
                default: total_pix <= total_pix;
            endcase
        end
    end

    // Row r comes from buffer rd_sel+r (oldest first), column c+col.
    always_comb begin
        window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int col = 0; col < 3; col++) begin
                window[(3*r + col)*PIX_W +: PIX_W] =
                    lb[2'(rd_sel + 2'(r))][rd_cnt + AW'(col)];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state              <= IDLE;
            rd_cnt             <= '0;
            rd_sel             <= '0;
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_pixel_data_valid <= 1'b0;
                    o_intr             <= 1'b0;
                    if (total_pix >= FILL_THR) begin
                        state  <= READ;
                        rd_cnt <= '0;
                    end
                end
                default: begin
                    o_pixel_data       <= window;
                    o_pixel_data_valid <= 1'b1;
                    if (line_done) begin
                        rd_cnt <= '0;
                        rd_sel <= rd_sel + 2'd1;
                        o_intr <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + AW'(1);
                        o_intr <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_window_ctrl.sv
// Directed bench for image_window_ctrl with IMG_WIDTH=8; pixel value = line*16 + column.
module tb_image_window_ctrl;

    localparam int W = 8;

    typedef struct {
        logic        valid;
        logic        intr;
        logic [71:0] win;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [7:0]  i_pixel_data = 8'h00;
    logic        i_pixel_data_valid = 1'b0;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;

    int errors = 0;
    int checks = 0;

    int          valid_total = 0;
    int          intr_total = 0;
    logic        prev_valid = 1'b0;
    logic [71:0] first_win[$];

    vec_t tbl[9];

    image_window_ctrl #(.IMG_WIDTH(W), .PIX_W(8)) dut (
        .i_clk              (i_clk),
        .i_rstn             (i_rstn),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr)
    );

    always #5 i_clk = ~i_clk;

    // Output monitor: counts valid windows and interrupts, records each pass's first window.
    always @(negedge i_clk) begin
        if (o_pixel_data_valid) begin
            valid_total <= valid_total + 1;
            if (!prev_valid) first_win.push_back(o_pixel_data);
        end
        if (o_intr) intr_total <= intr_total + 1;
        prev_valid <= o_pixel_data_valid;
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_dut();
        i_pixel_data_valid = 1'b0;
        i_rstn = 1'b0;
        tick();
        tick();
        i_rstn = 1'b1;
    endtask

    task automatic send_pix(input logic [7:0] v, input int gap);
        i_pixel_data = v;
        i_pixel_data_valid = 1'b1;
        tick();
        i_pixel_data_valid = 1'b0;
        i_pixel_data = 8'hEE;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic send_line(input int line);
        for (int c = 0; c < W; c++) send_pix(8'(line*16 + c), 0);
    endtask

    // Called right after the 24th pixel is accepted; entry k is sampled k negedges later.
    task automatic run_table(input string tag);
        for (int k = 0; k < 9; k++) begin
            @(negedge i_clk);
            check($sformatf("%s_valid[%0d]", tag, k), 72'(o_pixel_data_valid), 72'(tbl[k].valid));
            check($sformatf("%s_intr[%0d]", tag, k), 72'(o_intr), 72'(tbl[k].intr));
            if (tbl[k].valid)
                check($sformatf("%s_win[%0d]", tag, k), o_pixel_data, tbl[k].win);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vb;
        int ib;
        int fb;
        int guard;

        tbl[0] = '{1'b0, 1'b0, 72'h0};
        tbl[1] = '{1'b0, 1'b0, 72'h0};
        tbl[2] = '{1'b1, 1'b0, 72'h22_21_20_12_11_10_02_01_00};
        tbl[3] = '{1'b1, 1'b0, 72'h23_22_21_13_12_11_03_02_01};
        tbl[4] = '{1'b1, 1'b0, 72'h24_23_22_14_13_12_04_03_02};
        tbl[5] = '{1'b1, 1'b0, 72'h25_24_23_15_14_13_05_04_03};
        tbl[6] = '{1'b1, 1'b0, 72'h26_25_24_16_15_14_06_05_04};
        tbl[7] = '{1'b1, 1'b1, 72'h27_26_25_17_16_15_07_06_05};
        tbl[8] = '{1'b0, 1'b0, 72'h0};

        // Reset state
        reset_dut();
        @(negedge i_clk);
        check("rst_valid", 72'(o_pixel_data_valid), 72'd0);
        check("rst_intr", 72'(o_intr), 72'd0);
        check("rst_data", o_pixel_data, 72'd0);
        tick();

        // First window: three lines back to back
        for (int l = 0; l < 3; l++) send_line(l);
        run_table("first");
        vb = valid_total;
        for (int i = 0; i < 20; i++) tick();
        check("first_no_extra", 72'(valid_total - vb), 72'd0);

        // Overlapped line: line 3 streams during the first readout
        reset_dut();
        vb = valid_total; ib = intr_total; fb = first_win.size();
        for (int l = 0; l < 4; l++) send_line(l);
        for (int i = 0; i < 40; i++) tick();
        check("ovl_intr_cnt", 72'(intr_total - ib), 72'd2);
        check("ovl_valid_cnt", 72'(valid_total - vb), 72'd12);
        check("ovl_pass_cnt", 72'(first_win.size() - fb), 72'd2);
        if (first_win.size() - fb >= 2) begin
            check("ovl_pass1_win", first_win[fb], 72'h22_21_20_12_11_10_02_01_00);
            check("ovl_pass2_win", first_win[fb+1], 72'h32_31_30_22_21_20_12_11_10);
        end
        check("ovl_total_pix", 72'(dut.total_pix), 72'd16);

        // Buffer wrap: seven lines, one extra line per interrupt after the first four
        reset_dut();
        ib = intr_total; fb = first_win.size();
        for (int l = 0; l < 4; l++) send_line(l);
        for (int l = 4; l < 7; l++) begin
            guard = 0;
            while ((intr_total - ib) < (l - 3) && guard < 200) begin
                tick();
                guard++;
            end
            check($sformatf("wrap_wait_line%0d", l), 72'(guard >= 200), 72'd0);
            send_line(l);
        end
        for (int i = 0; i < 60; i++) tick();
        check("wrap_intr_cnt", 72'(intr_total - ib), 72'd5);
        check("wrap_pass_cnt", 72'(first_win.size() - fb), 72'd5);
        if (first_win.size() - fb >= 5) begin
            check("wrap_pass3_win", first_win[fb+2], 72'h42_41_40_32_31_30_22_21_20);
            check("wrap_pass5_win", first_win[fb+4], 72'h62_61_60_52_51_50_42_41_40);
        end

        // Gapped input: one valid cycle in three
        reset_dut();
        vb = valid_total;
        for (int i = 0; i < 24; i++) begin
            if (i == 23) check("gap_early_valid", 72'(valid_total - vb), 72'd0);
            send_pix(8'((i / 8) * 16 + (i % 8)), (i == 23) ? 0 : 2);
        end
        run_table("gap");

        // Reset in the middle of a readout
        reset_dut();
        for (int l = 0; l < 3; l++) send_line(l);
        for (int k = 0; k < 5; k++) @(negedge i_clk);
        check("rstmid_pre_valid", 72'(o_pixel_data_valid), 72'd1);
        i_rstn = 1'b0;
        #1;
        check("rstmid_valid", 72'(o_pixel_data_valid), 72'd0);
        check("rstmid_intr", 72'(o_intr), 72'd0);
        check("rstmid_data", o_pixel_data, 72'd0);
        tick();
        tick();
        i_rstn = 1'b1;
        vb = valid_total;
        send_line(0);
        send_line(1);
        for (int i = 0; i < 10; i++) tick();
        check("rstmid_16pix_valid", 72'(valid_total - vb), 72'd0);
        send_line(2);
        run_table("rstmid_after");

        // Below threshold: 23 pixels never start a readout
        reset_dut();
        vb = valid_total; ib = intr_total;
        for (int i = 0; i < 23; i++) send_pix(8'((i / 8) * 16 + (i % 8)), 0);
        for (int i = 0; i < 100; i++) tick();
        check("below_valid_cnt", 72'(valid_total - vb), 72'd0);
        check("below_intr_cnt", 72'(intr_total - ib), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
